// File: rtl/dsp_mac_pkg.sv
// rtl/dsp_mac_pkg.sv - shared state encoding and slice constants for the DSP48A1 MAC sequencer
package dsp_mac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // OPMODE encodings: X=M with Z=0, Z=P or Z=C respectively
    localparam logic [7:0] OPM_FIRST = 8'h01;
    localparam logic [7:0] OPM_ACC   = 8'h09;
    localparam logic [7:0] OPM_BIAS  = 8'h0D;

    localparam int SLICE_LAT = 3;

endpackage

// File: rtl/dsp_mac_tagpipe.sv
// rtl/dsp_mac_tagpipe.sv - valid/first tag pipeline that times OPMODE and CEP against the slice registers
module dsp_mac_tagpipe
    import dsp_mac_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       acc,
    input  logic       first,
    input  logic [7:0] first_opm,
    output logic [7:0] opmode,
    output logic       cep
);

    logic v1;
    logic v2;

    // opmode register carries the "first" tag for the pair now sitting in A1/B1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1     <= 1'b0;
            v2     <= 1'b0;
            opmode <= 8'h00;
        end else if (clr) begin
            v1     <= 1'b0;
            v2     <= 1'b0;
            opmode <= OPM_ACC;
        end else begin
            v1     <= acc;
            v2     <= v1;
            opmode <= (acc && first) ? first_opm : OPM_ACC;
        end
    end

    assign cep = v2;

endmodule

// File: rtl/dsp_mac_seq.sv
// rtl/dsp_mac_seq.sv - DSP48A1 dot-product sequencer; define DSP_MAC_BIAS_EN to add a C-port bias
module dsp_mac_seq
    import dsp_mac_pkg::*;
#(
    parameter int WIDTH_2 = 18,
    parameter int WIDTH_4 = 48,
    parameter int LEN_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               abort,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [WIDTH_2-1:0] s_a,
    input  logic [WIDTH_2-1:0] s_b,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [WIDTH_4-1:0] res_data,
    output logic               busy,
    output logic [WIDTH_2-1:0] dsp_a,
    output logic [WIDTH_2-1:0] dsp_b,
    output logic [7:0]         dsp_opmode,
    output logic               dsp_cea,
    output logic               dsp_ceb,
    output logic               dsp_cem,
    output logic               dsp_ceopmode,
    output logic               dsp_cep,
    output logic               dsp_rstp,
    input  logic [WIDTH_4-1:0] dsp_p
`ifdef DSP_MAC_BIAS_EN
    ,
    input  logic [WIDTH_4-1:0] cfg_bias,
    output logic [WIDTH_4-1:0] dsp_c
`endif
);

    state_t             state;
    logic [LEN_W-1:0]   cnt;
    logic [LEN_W-1:0]   len_m1;
    logic [1:0]         drain_cnt;
    logic [WIDTH_4-1:0] res_q;
    logic               rstp_q;
    logic               accept;
    logic               first;
    logic [7:0]         first_opm;

    assign s_ready   = (state == RUN);
    assign res_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign accept    = s_valid && s_ready;
    assign first     = (cnt == '0);
    assign res_data  = res_q;
    assign dsp_rstp  = rstp_q;

    // Slice input registers may capture idle garbage; CEP gating keeps P clean
    assign dsp_a        = s_a;
    assign dsp_b        = s_b;
    assign dsp_cea      = 1'b1;
    assign dsp_ceb      = 1'b1;
    assign dsp_cem      = 1'b1;
    assign dsp_ceopmode = 1'b1;

`ifdef DSP_MAC_BIAS_EN
    logic [WIDTH_4-1:0] bias_q;

    assign first_opm = OPM_BIAS;
    assign dsp_c     = bias_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bias_q <= '0;
        end else if (!abort && state == IDLE && start) begin
            bias_q <= cfg_bias;
        end
    end
`else
    assign first_opm = OPM_FIRST;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            len_m1    <= '0;
            drain_cnt <= '0;
            res_q     <= '0;
            rstp_q    <= 1'b0;
        end else if (abort) begin
            state     <= IDLE;
            cnt       <= '0;
            drain_cnt <= '0;
            rstp_q    <= 1'b1;
        end else begin
            rstp_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt    <= '0;
                        len_m1 <= cfg_len - LEN_W'(1);
                        if (cfg_len == '0) begin
                            state <= DONE;
`ifdef DSP_MAC_BIAS_EN
                            res_q <= cfg_bias;
`else
                            res_q <= '0;
`endif
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        cnt <= cnt + LEN_W'(1);
                        if (cnt == len_m1) begin
                            state     <= DRAIN;
                            drain_cnt <= '0;
                        end
                    end
                end
                DRAIN: begin
                    // last product lands in P after the full slice latency
                    if (drain_cnt == 2'(SLICE_LAT - 1)) begin
                        state     <= DONE;
                        res_q     <= dsp_p;
                        drain_cnt <= '0;
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    dsp_mac_tagpipe u_tagpipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (abort),
        .acc       (accept),
        .first     (first),
        .first_opm (first_opm),
        .opmode    (dsp_opmode),
        .cep       (dsp_cep)
    );

endmodule

// File: tb/tb_dsp_mac_seq.sv
// tb/tb_dsp_mac_seq.sv - scoreboard bench for dsp_mac_seq with a behavioural DSP48A1 slice model
module tb_dsp_mac_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  cfg_len;
    logic        abort;
    logic        s_valid;
    logic        s_ready;
    logic [17:0] s_a;
    logic [17:0] s_b;
    logic        res_valid;
    logic        res_ready;
    logic [47:0] res_data;
    logic        busy;
    logic [17:0] dsp_a;
    logic [17:0] dsp_b;
    logic [7:0]  dsp_opmode;
    logic        dsp_cea, dsp_ceb, dsp_cem, dsp_ceopmode, dsp_cep, dsp_rstp;
    logic [47:0] dsp_p;
`ifdef DSP_MAC_BIAS_EN
    logic [47:0] cfg_bias;
    logic [47:0] dsp_c;
`endif

    dsp_mac_seq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .cfg_len      (cfg_len),
        .abort        (abort),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_a          (s_a),
        .s_b          (s_b),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .busy         (busy),
        .dsp_a        (dsp_a),
        .dsp_b        (dsp_b),
        .dsp_opmode   (dsp_opmode),
        .dsp_cea      (dsp_cea),
        .dsp_ceb      (dsp_ceb),
        .dsp_cem      (dsp_cem),
        .dsp_ceopmode (dsp_ceopmode),
        .dsp_cep      (dsp_cep),
        .dsp_rstp     (dsp_rstp),
        .dsp_p        (dsp_p)
`ifdef DSP_MAC_BIAS_EN
        ,
        .cfg_bias     (cfg_bias),
        .dsp_c        (dsp_c)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Slice model: A1/B1 -> M -> P, OPMODE registered, P gated by CEP
    logic [17:0]        a1 = '0;
    logic [17:0]        b1 = '0;
    logic signed [35:0] m = '0;
    logic [7:0]         opm_r = '0;
    logic [47:0]        p = '0;
    logic [47:0]        c_r = '0;
    logic [47:0]        x_sel;
    logic [47:0]        z_sel;

    always_comb begin
        x_sel = (opm_r[1:0] == 2'b01) ? {{12{m[35]}}, m} : 48'd0;
        case (opm_r[3:2])
            2'b10:   z_sel = p;
            2'b11:   z_sel = c_r;
            default: z_sel = 48'd0;
        endcase
    end

    always @(posedge clk) begin
        a1    <= dsp_a;
        b1    <= dsp_b;
        m     <= $signed(a1) * $signed(b1);
        opm_r <= dsp_opmode;
        if (dsp_rstp)
            p <= '0;
        else if (dsp_cep)
            p <= z_sel + x_sel;
    end

`ifdef DSP_MAC_BIAS_EN
    always @(posedge clk) c_r <= dsp_c;
`endif

    assign dsp_p = p;

    int n_cmp = 0;
    int n_err = 0;
    int cep_cnt = 0;
    int rstp_cnt = 0;
    int ready_cnt = 0;
    logic [47:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out waiting on DUT", name);
    endtask

    task automatic monitor();
        logic [47:0] e;
        forever begin
            @(negedge clk);
            if (dsp_cep)  cep_cnt++;
            if (dsp_rstp) rstp_cnt++;
            if (s_ready)  ready_cnt++;
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_result: got %0d with no job outstanding", res_data);
                end else begin
                    e = exp_q.pop_front();
                    check("res_data", 64'(res_data), 64'(e));
                end
            end
        end
    endtask

    task automatic start_job(input logic [7:0] len);
        start   = 1'b1;
        cfg_len = len;
        @(posedge clk); #1;
        start   = 1'b0;
    endtask

    task automatic send(input logic [17:0] a, input logic [17:0] b, output int acc_cyc);
        int g;
        s_valid = 1'b1;
        s_a     = a;
        s_b     = b;
        g       = 0;
        acc_cyc = -1;
        @(negedge clk);
        while (!s_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (!s_ready) fail_timeout("send");
        acc_cyc = cyc;
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic wait_valid(output int vc);
        int g;
        g = 0;
        @(negedge clk);
        while (!res_valid && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (!res_valid) fail_timeout("wait_valid");
        vc = cyc;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        @(negedge clk);
        while (busy && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (busy) fail_timeout("wait_idle");
        @(posedge clk); #1;
    endtask

    task automatic stimulus();
        int t0, t1, vc, base;

        // Reset state
        @(negedge clk);
        check("rst_s_ready",   64'(s_ready),    64'd0);
        check("rst_res_valid", 64'(res_valid),  64'd0);
        check("rst_res_data",  64'(res_data),   64'd0);
        check("rst_busy",      64'(busy),       64'd0);
        check("rst_opmode",    64'(dsp_opmode), 64'h00);
        check("rst_cep",       64'(dsp_cep),    64'd0);
        check("rst_rstp",      64'(dsp_rstp),   64'd0);
        check("rst_ce_all",    64'({dsp_cea, dsp_ceb, dsp_cem, dsp_ceopmode}), 64'hF);
        check("rst_dsp_a",     64'(dsp_a),      64'd123);
        check("rst_dsp_b",     64'(dsp_b),      64'd77);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic dot product: 2*5 - 3*6 + 4*7 = 20
        exp_q.push_back(48'd20);
        start_job(8'd3);
        send(18'sd2, 18'sd5, t0);
        send(-18'sd3, 18'sd6, t1);
        send(18'sd4, 18'sd7, t1);
        wait_valid(vc);
        check("latency_first_accept_to_valid", 64'(vc - t0), 64'd6);
        @(negedge clk);
        check("busy_after_handshake", 64'(busy), 64'd0);
        @(posedge clk); #1;

        // Bubbles: 4 * (3*3) = 36, CEP exactly 4 cycles
        base = cep_cnt;
        exp_q.push_back(48'd36);
        start_job(8'd4);
        for (int i = 0; i < 4; i++) begin
            send(18'sd3, 18'sd3, t1);
            if (i < 3) begin
                repeat (2) @(posedge clk);
                #1;
            end
        end
        wait_idle();
        check("bubble_cep_cycles", 64'(cep_cnt - base), 64'd4);

        // Zero length, then an immediate LEN=1 job with the most negative operands
        base = ready_cnt;
        exp_q.push_back(48'd0);
        start_job(8'd0);
        @(negedge clk);
        check("len0_valid_next_cycle", 64'(res_valid), 64'd1);
        @(posedge clk); #1;
        check("len0_ready_never", 64'(ready_cnt - base), 64'd0);
        exp_q.push_back(48'd17179869184);
        start_job(8'd1);
        send(-18'sd131072, -18'sd131072, t1);
        wait_idle();

        // Abort after two accepts, then LEN=1 (1,1)
        base = rstp_cnt;
        start_job(8'd5);
        send(18'sd7, 18'sd9, t1);
        send(18'sd11, 18'sd13, t1);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_rstp_pulse", 64'(dsp_rstp), 64'd1);
        repeat (4) @(posedge clk);
        #1;
        exp_q.push_back(48'd1);
        start_job(8'd1);
        send(18'sd1, 18'sd1, t1);
        wait_idle();
        check("abort_rstp_count", 64'(rstp_cnt - base), 64'd1);

        // Result backpressure with START pulses while in DONE
        res_ready = 1'b0;
        exp_q.push_back(48'd6);
        start_job(8'd1);
        send(18'sd2, 18'sd3, t1);
        wait_valid(vc);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            start   = (i % 3 == 0);
            cfg_len = 8'd7;
            @(negedge clk);
            check("bp_valid_held", 64'(res_valid), 64'd1);
            check("bp_data_held",  64'(res_data),  64'd6);
        end
        @(posedge clk); #1;
        start     = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_idle_after_handshake", 64'(busy), 64'd0);
        check("bp_start_ignored", 64'(s_ready), 64'd0);
        @(posedge clk); #1;

`ifdef DSP_MAC_BIAS_EN
        // Bias: -100 + 10*10 + 1*2 = 2; LEN=0 returns the bias itself
        cfg_bias = -48'sd100;
        exp_q.push_back(48'd2);
        start_job(8'd2);
        send(18'sd10, 18'sd10, t1);
        send(18'sd1, 18'sd2, t1);
        wait_idle();
        exp_q.push_back(-48'sd100);
        start_job(8'd0);
        wait_idle();
`endif

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        cfg_len   = 8'd0;
        abort     = 1'b0;
        s_valid   = 1'b0;
        s_a       = 18'd123;
        s_b       = 18'd77;
        res_ready = 1'b1;
`ifdef DSP_MAC_BIAS_EN
        cfg_bias  = 48'd0;
`endif
        fork
            monitor();
            stimulus();
        join_any
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
